instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch front end of the RV32 single-cycle core. It is the supplier side of the control-unit interface: it drives the instruction (opCode, funct3, full word) into decode, and consumes the PCWre/PCSrc decision back from control.
- Holds the PC and runs a request/acknowledge handshake to instruction memory, which has variable latency.
- Presents one instruction at a time, holds it until execute accepts it, then updates the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, cycles to wait for imem_ack before flagging an error; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  32  fetch byte address, equal to pc while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr, opCode, funct3 and pc_out are valid.
- instr  out  32  latched instruction word.
- opCode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- pc_out  out  32  address of the presented instruction.
- exec_ack  in  1  execute consumes the instruction; PCWre, PCSrc and branch_imm are valid this cycle.
- PCWre  in  1  0 means halt (from control).
- PCSrc  in  1  1 means take the branch (from control).
- branch_imm  in  32  sign-extended byte offset for branches.
- halted  out  1  sticky; core is halted.
- fetch_err  out  1  sticky; timeout or misaligned target.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0, wait counter=0.
  - instr_valid, halted, fetch_err and imem_req all 0.
- States: IDLE, REQ, ISSUE, HALT, ERR.
- IDLE: unconditionally moves to REQ on the next rising edge.
- REQ:
  - imem_req=1 and imem_addr=pc, both combinational from state; stable until ack.
  - The wait counter increments every cycle without ack.
  - On imem_ack: instr<=imem_rdata, counter<=0, next state ISSUE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack: next state ERR. An ack arriving in that same cycle wins (go to ISSUE).
  - Minimum latency from entering REQ to instr_valid is 1 cycle (ack arrives in the first REQ cycle).
- ISSUE:
  - instr_valid=1; instr, opCode, funct3 and pc_out are held stable until exec_ack.
  - On exec_ack with PCWre=0: next state HALT; pc unchanged.
  - On exec_ack with PCWre=1: next_pc = PCSrc ? pc+branch_imm : pc+4, computed modulo 2^32 (wraps, no overflow flag).
  - If next_pc[1:0]!=0: next state ERR, pc unchanged.
  - Otherwise pc<=next_pc and next state REQ.
- HALT: halted=1, instr_valid=0, imem_req=0. Stays here until reset.
- ERR: fetch_err=1, instr_valid=0, imem_req=0. Stays here until reset.
- Ignored inputs:
  - imem_ack outside REQ is ignored; a late ack after a timeout is dropped.
  - exec_ack outside ISSUE is ignored.
  - PCWre, PCSrc and branch_imm are sampled only on the exec_ack cycle.
- Only one fetch is outstanding at a time; there are no flushes and no speculative fetches.
- Reset asserted mid-handshake aborts immediately and drops imem_req asynchronously. Memory must tolerate an abandoned request.
- opCode 7'b1111111 is presented normally; the halt decision comes only through PCWre.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt (32 bits): increments on each imem_ack accepted in REQ.
  - perf_stall_cnt (32 bits): increments on each REQ cycle without ack plus each ISSUE cycle without exec_ack.
- Both counters reset to 0 asynchronously, wrap at 2^32, and freeze in HALT/ERR.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Sequential fetch:
  - Stimulus: release reset, ack every request after 2 wait cycles with rdata=32'h00A00093; exec_ack one cycle after each instr_valid; PCWre=1, PCSrc=0.
  - Required: imem_addr sequence 0x0, 0x4, 0x8, 0xC; opCode=7'h13; funct3=0.
- Taken branch:
  - Stimulus: at pc=0x8, exec_ack with PCSrc=1 and branch_imm=32'hFFFF_FFF8.
  - Required: next imem_addr=0x0.
  - Stimulus: branch_imm=32'h0000_0010 from pc=0x8.
  - Required: next imem_addr=0x18.
- Halt:
  - Stimulus: rdata=32'h0000007F, exec_ack with PCWre=0.
  - Required: halted=1 the next cycle; imem_req stays 0 for 20 cycles; pc_out holds the halt address.
- Timeout:
  - Stimulus: TIMEOUT=16, never ack.
  - Required: fetch_err=1 exactly 16 cycles after imem_req rises; a later imem_ack changes nothing.
  - Stimulus: ack in cycle 16.
  - Required: state ISSUE, fetch_err=0.
- Misaligned target:
  - Stimulus: PCSrc=1, branch_imm=32'h2.
  - Required: fetch_err=1; pc_out unchanged.
- Reset mid-operation:
  - Stimulus: drop Reset while in REQ waiting for ack.
  - Required: imem_req=0 and pc=RESET_PC immediately; after release, first request to RESET_PC 2 cycles later (IDLE then REQ).
  - With IFU_PERF_CNT_EN defined: counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch front end: holds the PC, fetches one word at a time over a req/ack handshake
// and presents it to decode until execute accepts it. `IFU_PERF_CNT_EN adds perf counters.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        CLK,
   input  logic        Reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [6:0]  opCode,
   output logic [2:0]  funct3,
   output logic [31:0] pc_out,
   input  logic        exec_ack,
   input  logic        PCWre,
   input  logic        PCSrc,
   input  logic [31:0] branch_imm,
   output logic        halted,
   output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ISSUE = 3'd2,
      HALT  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam int unsigned     CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

   state_t           state, state_d;
   logic [31:0]      pc;
   logic [31:0]      next_pc;
   logic [CNT_W-1:0] wait_cnt;
   logic             ack_take;
   logic             exec_take;
   logic             timed_out;
   logic             target_misaligned;

   assign ack_take          = (state == REQ) && imem_ack;
   assign exec_take         = (state == ISSUE) && exec_ack;
   assign next_pc           = PCSrc ? (pc + branch_imm) : (pc + 32'd4);
   assign target_misaligned = (next_pc[1:0] != 2'b00);
   // A same-cycle ack always beats the timeout.
   assign timed_out         = TIMEOUT_EN && (wait_cnt == CNT_LAST) && !imem_ack;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:  state_d = REQ;
         REQ: begin
            if (imem_ack)       state_d = ISSUE;
            else if (timed_out) state_d = ERR;
         end
         ISSUE: begin
            if (exec_ack) begin
               if (!PCWre)                 state_d = HALT;
               else if (target_misaligned) state_d = ERR;
               else                        state_d = REQ;
            end
         end
         HALT:  state_d = HALT;
         ERR:   state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      fetch_err   = 1'b0;
      unique case (state)
         REQ:   imem_req    = 1'b1;
         ISSUE: instr_valid = 1'b1;
         HALT:  halted      = 1'b1;
         ERR:   fetch_err   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pc       <= RESET_PC;
         instr    <= 32'h0;
         wait_cnt <= '0;
      end else begin
         if (ack_take) instr <= imem_rdata;
         if (exec_take && PCWre && !target_misaligned) pc <= next_pc;
         if (state == REQ) wait_cnt <= imem_ack ? '0 : (wait_cnt + CNT_W'(1));
         else              wait_cnt <= '0;
      end
   end

   assign imem_addr = pc;
   assign pc_out    = pc;
   assign opCode    = instr[6:0];
   assign funct3    = instr[14:12];

`ifdef IFU_PERF_CNT_EN
   // Stalls count memory wait cycles plus cycles where execute holds off.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         perf_fetch_cnt <= 32'h0;
         perf_stall_cnt <= 32'h0;
      end else begin
         if (ack_take) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (((state == REQ) && !imem_ack) || ((state == ISSUE) && !exec_ack))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetch/branch/halt program with a
// scoreboard, plus hand sequences for timeout, misalignment and mid-handshake reset.
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  opCode;
   logic [2:0]  funct3;
   logic [31:0] pc_out;
   logic        exec_ack = 1'b0;
   logic        PCWre = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] branch_imm = 32'h0;
   logic        halted;
   logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   always #5 CLK = ~CLK;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .opCode     (opCode),
      .funct3     (funct3),
      .pc_out     (pc_out),
      .exec_ack   (exec_ack),
      .PCWre      (PCWre),
      .PCSrc      (PCSrc),
      .branch_imm (branch_imm),
      .halted     (halted),
      .fetch_err  (fetch_err)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] rdata;
      int          waits;
      logic        pcwre;
      logic        pcsrc;
      logic [31:0] imm;
      logic [31:0] exp_addr;
      logic [6:0]  exp_op;
      logic [2:0]  exp_f3;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic [6:0]  op;
      logic [2:0]  f3;
   } exp_t;

   vec_t vecs[10];
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   exp_fetch = 0;
   int   exp_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!imem_req && n < 64) begin
         step();
         n++;
      end
      check_bit({name, "_req_seen"}, imem_req, 1'b1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 64) begin
         step();
         n++;
      end
      check_bit({name, "_valid_seen"}, instr_valid, 1'b1);
   endtask

   task automatic sb_push(input logic [31:0] pc, input logic [31:0] word);
      exp_t e;
      e.pc   = pc;
      e.word = word;
      e.op   = word[6:0];
      e.f3   = word[14:12];
      sb_q.push_back(e);
   endtask

   task automatic sb_compare(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_sb: got instr_valid with nothing pending, expected a queued fetch", name);
      end else begin
         e = sb_q.pop_front();
         check({name, "_pc"},    pc_out, e.pc);
         check({name, "_instr"}, instr,  e.word);
         check({name, "_op"},    32'(opCode), 32'(e.op));
         check({name, "_f3"},    32'(funct3), 32'(e.f3));
      end
   endtask

   // Pulse reset, release it just after an edge, and step into the first REQ cycle.
   task automatic reset_to_req;
      Reset = 1'b0;
      imem_ack = 1'b0;
      exec_ack = 1'b0;
      step();
      Reset = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h00A00093, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h00, 7'h13, 3'h0};
      vecs[1] = '{32'h00A00093, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h04, 7'h13, 3'h0};
      vecs[2] = '{32'h00A00093, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h08, 7'h13, 3'h0};
      vecs[3] = '{32'h00A00093, 0, 1'b1, 1'b0, 32'h0000_0000, 32'h0C, 7'h13, 3'h0};
      vecs[4] = '{32'h00A00093, 3, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h10, 7'h13, 3'h0};
      vecs[5] = '{32'h00A00093, 1, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h08, 7'h13, 3'h0};
      vecs[6] = '{32'h00209463, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h00, 7'h63, 3'h1};
      vecs[7] = '{32'h0040A103, 2, 1'b1, 1'b0, 32'h0000_0000, 32'h04, 7'h03, 3'h2};
      vecs[8] = '{32'h00A00093, 2, 1'b1, 1'b1, 32'h0000_0010, 32'h08, 7'h13, 3'h0};
      vecs[9] = '{32'h0000007F, 1, 1'b0, 1'b0, 32'h0000_0000, 32'h18, 7'h7F, 3'h0};

      // Reset state
      #1 Reset = 1'b0;
      #10;
      check_bit("rst_req",    imem_req,    1'b0);
      check_bit("rst_valid",  instr_valid, 1'b0);
      check_bit("rst_halted", halted,      1'b0);
      check_bit("rst_err",    fetch_err,   1'b0);
      check("rst_pc",    pc_out, 32'h0);
      check("rst_instr", instr,  32'h0);
`ifdef IFU_PERF_CNT_EN
      check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
      check("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
      step();
      Reset = 1'b1;
      check_bit("idle_req", imem_req, 1'b0);
      step();

      // Table-driven program: sequential fetch, taken branches, halt
      for (int i = 0; i < 10; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         wait_req(tag);
         check({tag, "_addr"}, imem_addr, vecs[i].exp_addr);
         for (int w = 0; w < vecs[i].waits; w++) begin
            imem_ack = 1'b0;
            exec_ack = 1'b1;
            PCWre    = 1'b0;
            step();
         end
         exec_ack = 1'b0;
         check_bit({tag, "_req_held"}, imem_req, 1'b1);
         imem_ack   = 1'b1;
         imem_rdata = vecs[i].rdata;
         sb_push(vecs[i].exp_addr, vecs[i].rdata);
         step();
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         wait_valid(tag);
         check({tag, "_op_tbl"}, 32'(opCode), 32'(vecs[i].exp_op));
         check({tag, "_f3_tbl"}, 32'(funct3), 32'(vecs[i].exp_f3));
         sb_compare(tag);
         // A stray ack while presenting must not disturb the held word.
         imem_ack   = 1'b1;
         imem_rdata = 32'hFFFF_FFFF;
         step();
         imem_ack   = 1'b0;
         check_bit({tag, "_valid_hold"}, instr_valid, 1'b1);
         check({tag, "_instr_hold"}, instr, vecs[i].rdata);
         exec_ack   = 1'b1;
         PCWre      = vecs[i].pcwre;
         PCSrc      = vecs[i].pcsrc;
         branch_imm = vecs[i].imm;
         step();
         exec_ack   = 1'b0;
         PCSrc      = 1'b0;
         branch_imm = 32'h0;
         exp_fetch++;
         exp_stall += vecs[i].waits + 1;
      end

      // Halt: sticky, no further requests, PC frozen at the halt address
      check_bit("halt_flag",  halted,      1'b1);
      check_bit("halt_valid", instr_valid, 1'b0);
      check_bit("halt_err",   fetch_err,   1'b0);
      check("halt_pc", pc_out, 32'h18);
      begin
         logic any_req = 1'b0;
         for (int c = 0; c < 20; c++) begin
            exec_ack = 1'b1;
            PCWre    = 1'b1;
            imem_ack = 1'b1;
            step();
            any_req |= imem_req;
         end
         exec_ack = 1'b0;
         imem_ack = 1'b0;
         check_bit("halt_quiet_req", any_req, 1'b0);
      end
      check_bit("halt_sticky", halted, 1'b1);
      check("halt_pc_hold", pc_out, 32'h18);
`ifdef IFU_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, 32'(exp_fetch));
      check("perf_stall", perf_stall_cnt, 32'(exp_stall));
`endif

      // Timeout with no ack, then a late ack that must be dropped
      reset_to_req();
      check_bit("to_req_rise", imem_req, 1'b1);
      begin
         logic early_err = 1'b0;
         for (int k = 1; k < 16; k++) begin
            step();
            early_err |= fetch_err;
         end
         check_bit("to_no_early_err", early_err, 1'b0);
         check_bit("to_req_c15", imem_req, 1'b1);
      end
      step();
      check_bit("to_err", fetch_err, 1'b1);
      check_bit("to_req_drop", imem_req, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      check_bit("to_late_err",   fetch_err,   1'b1);
      check_bit("to_late_valid", instr_valid, 1'b0);
      check("to_late_instr", instr, 32'h0);

      // Ack in the final cycle before timeout wins
      reset_to_req();
      for (int k = 1; k < 16; k++) step();
      imem_ack   = 1'b1;
      imem_rdata = 32'h00A00093;
      sb_push(32'h0, 32'h00A00093);
      step();
      imem_ack = 1'b0;
      check_bit("ack16_valid", instr_valid, 1'b1);
      check_bit("ack16_err",   fetch_err,   1'b0);
      sb_compare("ack16");

      // Misaligned branch target from ISSUE
      exec_ack   = 1'b1;
      PCWre      = 1'b1;
      PCSrc      = 1'b1;
      branch_imm = 32'h2;
      step();
      exec_ack   = 1'b0;
      PCSrc      = 1'b0;
      branch_imm = 32'h0;
      check_bit("mis_err",   fetch_err,   1'b1);
      check_bit("mis_valid", instr_valid, 1'b0);
      check_bit("mis_req",   imem_req,    1'b0);
      check("mis_pc", pc_out, 32'h0);

      // Reset asserted mid-cycle while waiting for ack at a nonzero PC
      reset_to_req();
      imem_ack   = 1'b1;
      imem_rdata = 32'h00A00093;
      step();
      imem_ack = 1'b0;
      exec_ack = 1'b1;
      PCWre    = 1'b1;
      step();
      exec_ack = 1'b0;
      step();
      step();
      check_bit("mid_req_before", imem_req, 1'b1);
      check("mid_addr_before", imem_addr, 32'h4);
      #2 Reset = 1'b0;
      #1;
      check_bit("mid_req_drop", imem_req, 1'b0);
      check("mid_pc_reset", pc_out, 32'h0);
`ifdef IFU_PERF_CNT_EN
      check("mid_perf_fetch", perf_fetch_cnt, 32'h0);
      check("mid_perf_stall", perf_stall_cnt, 32'h0);
`endif
      step();
      Reset = 1'b1;
      check_bit("mid_idle_req", imem_req, 1'b0);
      step();
      check_bit("mid_first_req", imem_req, 1'b1);
      check("mid_first_addr", imem_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
